fifo2gmii_tx: RTL

FIFO2GMII_TX -- requirements
Module: fifo2gmii_tx

---
 rtl/fifo2gmii_tx_pkg.sv | 34 +++
 rtl/fifo2gmii_tx_crc32_d8.sv | 18 +
 rtl/fifo2gmii_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo2gmii_tx_pkg.sv
// Shared definitions for the FIFO-to-GMII UDP video transmitter: FSM encoding,
// frame byte offsets, packet/length constants and the IPv4 header checksum helper.
package fifo2gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_INFO,
    ST_PIXEL,
    ST_FCS,
    ST_IFG
  } state_e;

  localparam logic [10:0] OFF_HEADER     = 11'd8;
  localparam logic [10:0] OFF_INFO       = 11'd50;
  localparam logic [10:0] OFF_PIXEL      = 11'd53;
  localparam logic [10:0] OFF_FCS        = 11'd1333;
  localparam logic [10:0] FRAME_LEN      = 11'd1337;
  localparam logic [10:0] PIXELS_PER_PKT = 11'd640;
  localparam logic [15:0] IP_TOTAL_LEN   = 16'd1311;
  localparam logic [15:0] UDP_LEN        = 16'd1291;

  // Every header field except the addresses is fixed, so they are folded in as constants.
  function automatic logic [15:0] ip_checksum(input logic [31:0] src, input logic [31:0] dst);
    logic [19:0] sum;
    sum = 20'h04500 + 20'(IP_TOTAL_LEN) + 20'h04000 + 20'h04011
        + 20'(src[31:16]) + 20'(src[15:0]) + 20'(dst[31:16]) + 20'(dst[15:0]);
    sum = 20'(sum[15:0]) + 20'(sum[19:16]);
    sum = 20'(sum[15:0]) + 20'(sum[19:16]);
    return ~sum[15:0];
  endfunction

endpackage

// File: rtl/fifo2gmii_tx_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32 (poly 0x04C11DB7), LSB of the byte first.
module crc32_d8 (
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    logic [31:0] v_crc;
    v_crc = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (v_crc[0] ^ i_data[i]) v_crc = (v_crc >> 1) ^ 32'hEDB8_8320;
      else                      v_crc = v_crc >> 1;
    end
    o_crc = v_crc;
  end

endmodule

// File: rtl/fifo2gmii_tx.sv
// Streams 640 FIFO pixel words per UDP/IPv4 Ethernet frame onto GMII:
// preamble, fixed headers, line info, pixels, CRC-32 FCS, then the inter-frame gap.
module fifo2gmii_tx
  import fifo2gmii_tx_pkg::*;
#(
  parameter logic [47:0] mac_src       = 48'h00_11_22_33_44_55,
  parameter logic [47:0] mac_dst       = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] ipv4_src      = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [31:0] ipv4_dst_base = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] src_port      = 16'd12345,
  parameter logic [15:0] dst_port      = 16'd12345,
  parameter logic [7:0]  ifg_len       = 8'd12
) (
  input  logic        clk125,
  input  logic        sys_rst_n,
  input  logic        id,
  input  logic [28:0] fifo_dout,
  input  logic [10:0] fifo_cnt,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        busy,
  output logic        underrun
);

  state_e       r_state, w_state_nxt;
  logic [10:0]  r_cnt, w_cnt_nxt;
  logic [31:0]  r_crc, w_crc_nxt, w_fcs;
  logic         r_x;
  logic [10:0]  r_y;
  logic         w_start, w_load;
  logic [10:0]  w_ifg_last;
  logic [31:0]  w_ip_dst;
  logic [15:0]  w_ip_csum;
  logic [335:0] w_hdr;
  logic [5:0]   w_hidx;
  logic [8:0]   w_hpos;
  logic [1:0]   w_fidx;
  logic         w_unused;

  assign w_start    = fifo_cnt >= PIXELS_PER_PKT;
  assign w_ifg_last = {3'b000, ifg_len} - 11'd1;
  assign w_ip_dst   = {ipv4_dst_base[31:8], ipv4_dst_base[7:0] + {7'd0, id}};
  assign w_ip_csum  = ip_checksum(ipv4_src, w_ip_dst);
  assign w_unused   = fifo_dout[28];

  // Frame bytes 8..49, first transmitted byte in the MSBs.
  assign w_hdr = {mac_dst, mac_src, 16'h0800,
                  8'h45, 8'h00, IP_TOTAL_LEN, 16'h0000, 16'h4000, 8'd64, 8'h11,
                  w_ip_csum, ipv4_src, w_ip_dst,
                  src_port, dst_port, UDP_LEN, 16'h0000};
  assign w_hidx = 6'(r_cnt - OFF_HEADER);
  assign w_hpos = 9'd335 - {w_hidx, 3'b000};
  assign w_fidx = 2'(r_cnt - OFF_FCS);
  assign w_fcs  = ~r_crc;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 11'd1;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start) w_state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: if (r_cnt == OFF_HEADER - 11'd1) w_state_nxt = ST_HEADER;
      ST_HEADER:   if (r_cnt == OFF_INFO - 11'd1)   w_state_nxt = ST_INFO;
      ST_INFO:     if (r_cnt == OFF_PIXEL - 11'd1)  w_state_nxt = ST_PIXEL;
      ST_PIXEL:    if (r_cnt == OFF_FCS - 11'd1)    w_state_nxt = ST_FCS;
      ST_FCS: begin
        if (r_cnt == FRAME_LEN - 11'd1) begin
          w_state_nxt = ST_IFG;
          w_cnt_nxt   = '0;
        end
      end
      ST_IFG: begin
        if (r_cnt == w_ifg_last) begin
          w_state_nxt = w_start ? ST_PREAMBLE : ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_load = (w_state_nxt == ST_PREAMBLE) && (r_state != ST_PREAMBLE);

  always_comb begin
    txd        = 8'h00;
    tx_en      = 1'b0;
    fifo_rd_en = 1'b0;
    case (r_state)
      ST_PREAMBLE: begin
        tx_en = 1'b1;
        txd   = (r_cnt == OFF_HEADER - 11'd1) ? 8'hD5 : 8'h55;
      end
      ST_HEADER: begin
        tx_en = 1'b1;
        txd   = w_hdr[w_hpos -: 8];
      end
      ST_INFO: begin
        tx_en = 1'b1;
        if (r_cnt == OFF_INFO)              txd = 8'h00;
        else if (r_cnt == OFF_INFO + 11'd1) txd = r_y[7:0];
        else                                txd = {3'b000, r_x, 1'b0, r_y[10:8]};
      end
      ST_PIXEL: begin
        // Odd frame offsets carry the high byte; the low byte pops the FWFT word.
        tx_en      = 1'b1;
        fifo_rd_en = ~r_cnt[0];
        if (!fifo_empty) txd = r_cnt[0] ? fifo_dout[15:8] : fifo_dout[7:0];
      end
      ST_FCS: begin
        tx_en = 1'b1;
        txd   = w_fcs[{w_fidx, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign underrun = fifo_rd_en & fifo_empty;
  assign busy     = (r_state != ST_IDLE);

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (txd),
    .o_crc  (w_crc_nxt)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_crc   <= '1;
      r_x     <= 1'b0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state inside {ST_HEADER, ST_INFO, ST_PIXEL}) r_crc <= w_crc_nxt;
      else if (r_state != ST_FCS)                        r_crc <= '1;
      if (w_load) begin
        r_x <= fifo_dout[27];
        r_y <= fifo_dout[26:16];
      end
    end
  end

endmodule
